// File: rtl/usb_tx_ctrl.sv
// usb_tx_ctrl: transmit sequencer for the serial line path.
// Sends SYNC, then the payload LSB-first with bit stuffing, then EOP.
// Between packets the NRZI encoder is held at idle J through nrzi_rst_L.
// Every output except tx_ready is registered and changes only on bit-strobe edges.
// tx_ready is combinational so that a byte can be accepted in the cycle of the
// strobe that ends bit 7.
module usb_tx_ctrl #(
    parameter int          CLK_PER_BIT  = 1,
    parameter logic [7:0]  SYNC_PATTERN = 8'h80,
    parameter int          STUFF_LEN    = 6
) (
    input  logic       clk,
    input  logic       rst_L,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       nrzi_bit,
    output logic       nrzi_rst_L,
    output logic       se0,
    output logic       busy,
    output logic       underrun
);

    localparam int SW = $clog2(CLK_PER_BIT + 1);
    localparam int OW = $clog2(STUFF_LEN + 1);

    typedef enum logic [2:0] {IDLE, SYNC, DATA, STUFF, EOP1, EOP2, EOP3} state_t;

    state_t        state, state_n, ret_state, ret_state_n, adv_state;
    logic [2:0]    bit_idx, idx_n, ret_idx, ret_idx_n, adv_idx;
    logic [7:0]    cur, cur_n;
    logic          last, last_n;
    logic [OW-1:0] ones, ones_n, ones_inc;
    logic [SW-1:0] strb_cnt, strb_n;
    logic          strobe, bit_end, stuff_hit, ready_int;
    logic          nrzi_bit_n, nrzi_rst_L_n, se0_n, busy_n, underrun_n;

    assign strobe    = busy && (strb_cnt == SW'(CLK_PER_BIT - 1));
    // nrzi_bit holds the bit currently on the line, so it drives the ones count
    assign ones_inc  = nrzi_bit ? ones + OW'(1) : '0;
    assign stuff_hit = (ones_inc == OW'(STUFF_LEN));
    assign tx_ready  = rst_L && ready_int;

    // Next-state, byte handshake, stuffing decision and next registered outputs
    always_comb begin
        state_n     = state;
        ret_state_n = ret_state;
        idx_n       = bit_idx;
        ret_idx_n   = ret_idx;
        cur_n       = cur;
        last_n      = last;
        ones_n      = ones;
        underrun_n  = 1'b0;
        ready_int   = 1'b0;
        adv_state   = state;
        adv_idx     = bit_idx;
        bit_end     = 1'b0;
        strb_n      = (busy && !strobe) ? strb_cnt + SW'(1) : '0;

        case (state)
            IDLE: begin
                ready_int = 1'b1;
                if (tx_valid) begin
                    cur_n   = tx_data;
                    last_n  = tx_last;
                    state_n = SYNC;
                    idx_n   = 3'd0;
                    ones_n  = '0;
                end
            end
            SYNC: if (strobe) begin
                bit_end = 1'b1;
                if (bit_idx == 3'd7) begin
                    adv_state = DATA;
                    adv_idx   = 3'd0;
                end else begin
                    adv_idx = bit_idx + 3'd1;
                end
            end
            DATA: if (strobe) begin
                bit_end = 1'b1;
                if (bit_idx != 3'd7) begin
                    adv_idx = bit_idx + 3'd1;
                end else if (last) begin
                    adv_state = EOP1;
                end else begin
                    // byte boundary: the handshake decision is made now; a stuff bit
                    // triggered by bit 7 is still sent before the next byte or EOP
                    ready_int = 1'b1;
                    if (tx_valid) begin
                        cur_n   = tx_data;
                        last_n  = tx_last;
                        adv_idx = 3'd0;
                    end else begin
                        underrun_n = 1'b1;
                        adv_state  = EOP1;
                    end
                end
            end
            STUFF: if (strobe) begin
                ones_n  = '0;
                state_n = ret_state;
                idx_n   = ret_idx;
            end
            EOP1:    if (strobe) state_n = EOP2;
            EOP2:    if (strobe) state_n = EOP3;
            EOP3:    if (strobe) state_n = IDLE;
            default: state_n = IDLE;
        endcase

        if (bit_end) begin
            ones_n = ones_inc;
            if (stuff_hit) begin
                state_n     = STUFF;
                ret_state_n = adv_state;
                ret_idx_n   = adv_idx;
            end else begin
                state_n = adv_state;
                idx_n   = adv_idx;
            end
        end

        nrzi_bit_n   = 1'b1;
        nrzi_rst_L_n = 1'b1;
        se0_n        = 1'b0;
        busy_n       = 1'b1;
        case (state_n)
            IDLE:  begin nrzi_rst_L_n = 1'b0; busy_n = 1'b0; end
            SYNC:  nrzi_bit_n = SYNC_PATTERN[idx_n];
            DATA:  nrzi_bit_n = cur_n[idx_n];
            STUFF: nrzi_bit_n = 1'b0;
            EOP1:  se0_n = 1'b1;
            EOP2:  se0_n = 1'b1;
            EOP3:  nrzi_rst_L_n = 1'b0;
            default: begin nrzi_rst_L_n = 1'b0; busy_n = 1'b0; end
        endcase
    end

    // State, counters and registered outputs with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_L) begin
            state      <= IDLE;
            ret_state  <= IDLE;
            bit_idx    <= 3'd0;
            ret_idx    <= 3'd0;
            cur        <= 8'd0;
            last       <= 1'b0;
            ones       <= '0;
            strb_cnt   <= '0;
            nrzi_bit   <= 1'b1;
            nrzi_rst_L <= 1'b0;
            se0        <= 1'b0;
            busy       <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            state      <= state_n;
            ret_state  <= ret_state_n;
            bit_idx    <= idx_n;
            ret_idx    <= ret_idx_n;
            cur        <= cur_n;
            last       <= last_n;
            ones       <= ones_n;
            strb_cnt   <= strb_n;
            nrzi_bit   <= nrzi_bit_n;
            nrzi_rst_L <= nrzi_rst_L_n;
            se0        <= se0_n;
            busy       <= busy_n;
            underrun   <= underrun_n;
        end
    end

endmodule

// File: tb/tb_usb_tx_ctrl.sv
// tb_usb_tx_ctrl: scoreboard bench for usb_tx_ctrl.
// Expected line symbols {se0, nrzi_rst_L, nrzi_bit} are queued when a packet is driven
// and popped once per busy cycle. One DUT runs with CLK_PER_BIT=1, a second with 4.
module tb_usb_tx_ctrl;

    logic clk = 1'b0;
    logic rst_L = 1'b0;

    logic       tx_valid = 1'b0, tx_last = 1'b0;
    logic [7:0] tx_data = 8'd0;
    logic       tx_ready, nrzi_bit, nrzi_rst_L, se0, busy, underrun;

    logic       tx_valid4 = 1'b0, tx_last4 = 1'b0;
    logic [7:0] tx_data4 = 8'd0;
    logic       tx_ready4, nrzi_bit4, nrzi_rst_L4, se04, busy4, underrun4;

    always #5 clk = ~clk;

    usb_tx_ctrl #(.CLK_PER_BIT(1)) dut (
        .clk(clk), .rst_L(rst_L), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_last(tx_last), .tx_ready(tx_ready), .nrzi_bit(nrzi_bit),
        .nrzi_rst_L(nrzi_rst_L), .se0(se0), .busy(busy), .underrun(underrun));

    usb_tx_ctrl #(.CLK_PER_BIT(4)) dut4 (
        .clk(clk), .rst_L(rst_L), .tx_valid(tx_valid4), .tx_data(tx_data4),
        .tx_last(tx_last4), .tx_ready(tx_ready4), .nrzi_bit(nrzi_bit4),
        .nrzi_rst_L(nrzi_rst_L4), .se0(se04), .busy(busy4), .underrun(underrun4));

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // reference stream builder
    logic [2:0] stream[$];
    logic [2:0] q1[$];
    logic [2:0] q4[$];
    int         m_ones;

    task automatic put_bit(input logic b);
        stream.push_back({1'b0, 1'b1, b});
        if (b) m_ones++; else m_ones = 0;
        if (m_ones == 6) begin
            stream.push_back(3'b010);
            m_ones = 0;
        end
    endtask

    task automatic build(input logic [7:0] b0, input logic [7:0] b1, input int n);
        logic [7:0] sp;
        logic [7:0] cb;
        sp = 8'h80;
        stream.delete();
        m_ones = 0;
        for (int i = 0; i < 8; i++) put_bit(sp[i]);
        for (int k = 0; k < n; k++) begin
            cb = (k == 0) ? b0 : b1;
            for (int i = 0; i < 8; i++) put_bit(cb[i]);
        end
        stream.push_back(3'b111);
        stream.push_back(3'b111);
        stream.push_back(3'b001);
    endtask

    // monitors
    bit mon_en = 1'b1;
    int busy_cnt = 0, rdy_cnt = 0, und_cnt = 0;
    int busy4_cnt = 0, rdy4_cnt = 0, hold_err4 = 0;
    logic [2:0] prev4 = 3'b000;
    int         run4 = 0;

    // pop one expected symbol per busy cycle of the CPB=1 instance
    always @(negedge clk) begin
        if (mon_en && busy) begin
            logic [2:0] e;
            busy_cnt++;
            if (tx_ready) rdy_cnt++;
            if (underrun) begin
                und_cnt++;
                chk(se0 == 1'b1, "underrun_in_eop1", int'(se0), 1);
            end
            if (q1.size() == 0) begin
                chk(1'b0, "extra_busy_cycle", busy_cnt, 0);
            end else begin
                e = q1.pop_front();
                chk({se0, nrzi_rst_L, nrzi_bit} == e, "line_symbol",
                    int'({se0, nrzi_rst_L, nrzi_bit}), int'(e));
            end
        end
    end

    // CPB=4 instance: symbol compare plus check each symbol is held in runs of 4
    always @(negedge clk) begin
        if (busy4) begin
            logic [2:0] e;
            logic [2:0] s;
            s = {se04, nrzi_rst_L4, nrzi_bit4};
            busy4_cnt++;
            if (tx_ready4) rdy4_cnt++;
            if (busy4_cnt % 4 == 1) prev4 = s;
            else if (s != prev4) hold_err4++;
            if (q4.size() == 0) begin
                chk(1'b0, "cpb4_extra_busy", busy4_cnt, 0);
            end else begin
                e = q4.pop_front();
                chk(s == e, "cpb4_line_symbol", int'(s), int'(e));
            end
        end
    end

    // drive one packet into the CPB=1 instance and check the idle state after it
    task automatic send1(input logic [7:0] b0, input logic [7:0] b1, input int n,
                         input bit und, input int exp_busy, input int exp_rdy);
        int t;
        build(b0, b1, n);
        foreach (stream[i]) q1.push_back(stream[i]);
        busy_cnt = 0; rdy_cnt = 0; und_cnt = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            tx_valid = 1'b1;
            tx_data  = (k == 0) ? b0 : b1;
            tx_last  = (k == n - 1) && !und;
            t = 0;
            while (!tx_ready && t < 200) begin
                @(negedge clk);
                t++;
            end
            if (t >= 200) chk(1'b0, "ready_timeout", t, 0);
            @(posedge clk);
        end
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = 8'hxx;
        t = 0;
        while (busy && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk(!busy, "busy_timeout", int'(busy), 0);
        chk(busy_cnt == exp_busy, "busy_cycles", busy_cnt, exp_busy);
        chk(rdy_cnt == exp_rdy, "ready_pulses", rdy_cnt, exp_rdy);
        chk(und_cnt == (und ? 1 : 0), "underrun_pulses", und_cnt, und ? 1 : 0);
        chk(q1.size() == 0, "symbols_left", q1.size(), 0);
        chk({tx_ready, nrzi_rst_L, se0, nrzi_bit} == 4'b1001, "idle_outputs",
            int'({tx_ready, nrzi_rst_L, se0, nrzi_bit}), 9);
        $display("packet b0=%02h b1=%02h n=%0d und=%0d busy=%0d ready=%0d",
                 b0, b1, n, und, busy_cnt, rdy_cnt);
    endtask

    typedef struct {
        logic [7:0] b0;
        logic [7:0] b1;
        int         n;
        bit         und;
        int         exp_busy;
        int         exp_rdy;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int t;
        vecs[0] = '{8'h00, 8'h00, 1, 1'b0, 19, 0};
        vecs[1] = '{8'hFF, 8'h00, 1, 1'b0, 20, 0};
        vecs[2] = '{8'hA5, 8'h3C, 2, 1'b0, 27, 1};
        vecs[3] = '{8'hFC, 8'h00, 1, 1'b0, 20, 0};
        vecs[4] = '{8'hC0, 8'h0F, 2, 1'b0, 28, 1};
        vecs[5] = '{8'h01, 8'h00, 1, 1'b1, 19, 1};

        repeat (3) @(negedge clk);
        chk({busy, se0, nrzi_rst_L, nrzi_bit, underrun, tx_ready} == 6'b000100,
            "reset_state", int'({busy, se0, nrzi_rst_L, nrzi_bit, underrun, tx_ready}), 4);
        chk({busy4, se04, nrzi_rst_L4, nrzi_bit4, underrun4, tx_ready4} == 6'b000100,
            "reset_state4", int'({busy4, se04, nrzi_rst_L4, nrzi_bit4, underrun4, tx_ready4}), 4);
        rst_L = 1'b1;
        @(negedge clk);
        chk(tx_ready == 1'b1, "idle_ready", int'(tx_ready), 1);

        for (int v = 0; v < 6; v++)
            send1(vecs[v].b0, vecs[v].b1, vecs[v].n, vecs[v].und,
                  vecs[v].exp_busy, vecs[v].exp_rdy);

        // reset in the middle of DATA bit 3
        build(8'h55, 8'h00, 1);
        foreach (stream[i]) q1.push_back(stream[i]);
        @(negedge clk);
        tx_valid = 1'b1; tx_data = 8'h55; tx_last = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (11) @(negedge clk);
        mon_en = 1'b0;
        chk(busy == 1'b1, "busy_before_reset", int'(busy), 1);
        rst_L = 1'b0;
        @(negedge clk);
        chk({busy, se0, nrzi_rst_L, nrzi_bit, underrun, tx_ready} == 6'b000100,
            "midpkt_reset", int'({busy, se0, nrzi_rst_L, nrzi_bit, underrun, tx_ready}), 4);
        rst_L = 1'b1;
        q1.delete();
        @(negedge clk);
        mon_en = 1'b1;
        send1(8'h00, 8'h00, 1, 1'b0, 19, 0);

        // CPB=4: two bytes, each symbol held 4 cycles, single 1-cycle ready pulse
        build(8'h80, 8'h01, 2);
        foreach (stream[i]) repeat (4) q4.push_back(stream[i]);
        busy4_cnt = 0; rdy4_cnt = 0; hold_err4 = 0;
        @(negedge clk);
        tx_valid4 = 1'b1; tx_data4 = 8'h80; tx_last4 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        tx_data4 = 8'h01; tx_last4 = 1'b1;
        t = 0;
        while (!tx_ready4 && t < 400) begin
            @(negedge clk);
            t++;
        end
        chk(t < 400, "cpb4_ready_timeout", t, 0);
        @(posedge clk);
        @(negedge clk);
        tx_valid4 = 1'b0;
        t = 0;
        while (busy4 && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk(busy4_cnt == 108, "cpb4_busy_cycles", busy4_cnt, 108);
        chk(rdy4_cnt == 1, "cpb4_ready_width", rdy4_cnt, 1);
        chk(hold_err4 == 0, "cpb4_bit_hold", hold_err4, 0);
        chk(q4.size() == 0, "cpb4_symbols_left", q4.size(), 0);
        $display("packet cpb4 b0=80 b1=01 busy=%0d ready=%0d", busy4_cnt, rdy4_cnt);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
